segment_scan_driver: RTL and testbench

//  N-digit multiplexed 7-segment driver; parametrised successor to the 2-digit segment_drive peripheral.

---
 rtl/segment_scan_driver_if.sv | 23 ++
 rtl/segment_scan_driver.sv | 147 ++++++++++++++
 tb/tb_segment_scan_driver.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/segment_scan_driver_if.sv
// Avalon-MM register bus for the multiplexed 7-segment scan driver.
// Handshake: a write is taken on every clock edge where avs_write is high;
// a read is taken on every edge where avs_read is high and avs_readdata
// carries the result from the following cycle until the next read.
interface segment_scan_driver_if #(
   parameter int ADDR_W = 4
);
   logic [ADDR_W-1:0] avs_address;
   logic              avs_write;
   logic [31:0]       avs_writedata;
   logic              avs_read;
   logic [31:0]       avs_readdata;

   modport master (
      output avs_address, avs_write, avs_writedata, avs_read,
      input  avs_readdata
   );

   modport slave (
      input  avs_address, avs_write, avs_writedata, avs_read,
      output avs_readdata
   );
endinterface

// File: rtl/segment_scan_driver.sv
// N-digit multiplexed 7-segment scan driver with per-digit byte registers,
// optional hex decode, 16-level PWM brightness and anti-ghost blanking.
module segment_scan_driver #(
   parameter int NUM_DIGITS  = 4,
   parameter int ADDR_W      = 4,
   parameter int SCAN_DIV    = 50000,
   parameter int BLANK_CYC   = 64,
   parameter int SEG_ACT_LOW = 1,
   parameter int DIG_ACT_LOW = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   segment_scan_driver_if.slave  avs,
   output logic [7:0]            segment_data,
   output logic [NUM_DIGITS-1:0] digit_en,
   output logic                  frame_tick
);
   localparam int CNT_W = $clog2(SCAN_DIV);
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int STEP  = SCAN_DIV / 16;
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
   localparam logic [ADDR_W-1:0] CTRL_ADDR = ADDR_W'(NUM_DIGITS);

   logic [7:0]            r_digit [NUM_DIGITS];
   logic [3:0]            r_bright;
   logic                  r_hex;
   logic                  r_en;
   logic [CNT_W-1:0]      r_cnt;
   logic [IDX_W-1:0]      r_idx;
   logic [7:0]            r_pat;
   logic [7:0]            r_seg;
   logic [NUM_DIGITS-1:0] r_dig;
   logic                  r_frame;
   logic [31:0]           r_readdata;

   logic [7:0]            w_cur_byte;
   logic [7:0]            w_new_pat;
   logic [7:0]            w_pat;
   logic [NUM_DIGITS-1:0] w_onehot;
   logic [31:0]           w_rdata;
   logic [31:0]           w_cnt32;
   logic [31:0]           w_limit;
   logic                  w_on;
   logic                  w_cnt_wrap;
   logic                  w_idx_wrap;

   function automatic logic [6:0] hex7seg(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
         4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
         4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
         4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
      endcase
      return s;
   endfunction

   // Register write port: digit bytes and the control word.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_DIGITS; i++) r_digit[i] <= 8'h00;
         r_bright <= 4'hF;
         r_hex    <= 1'b1;
         r_en     <= 1'b1;
      end else if (avs.avs_write) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (avs.avs_address == ADDR_W'(i)) r_digit[i] <= avs.avs_writedata[7:0];
         end
         if (avs.avs_address == CTRL_ADDR) begin
            r_bright <= avs.avs_writedata[11:8];
            r_hex    <= avs.avs_writedata[1];
            r_en     <= avs.avs_writedata[0];
         end
      end
   end

   // Read mux: unmapped addresses and unused bits return zero.
   always_comb begin
      w_rdata = 32'h0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (avs.avs_address == ADDR_W'(i)) w_rdata = {24'h0, r_digit[i]};
      end
      if (avs.avs_address == CTRL_ADDR) w_rdata = {20'h0, r_bright, 6'h0, r_hex, r_en};
   end

   // Read data register: loads on a read strobe, holds otherwise.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)             r_readdata <= 32'h0;
      else if (avs.avs_read) r_readdata <= w_rdata;
   end

   assign avs.avs_readdata = r_readdata;

   // Slot timing and the on/off decision for the current counter state.
   always_comb begin
      w_cur_byte = 8'h00;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         w_onehot[i] = (r_idx == IDX_W'(i));
         if (r_idx == IDX_W'(i)) w_cur_byte = r_digit[i];
      end
      w_new_pat  = r_hex ? {w_cur_byte[7], hex7seg(w_cur_byte[3:0])} : w_cur_byte;
      // At slot start the fresh pattern is used directly so a zero blanking
      // window still shows the right glyph on the first cycle.
      w_pat      = (r_cnt == '0) ? w_new_pat : r_pat;
      w_cnt32    = 32'(r_cnt);
      w_limit    = (32'(r_bright) + 32'd1) * 32'(STEP);
      w_on       = r_en && (w_cnt32 >= 32'(BLANK_CYC)) &&
                   ((r_bright == 4'hF) || (w_cnt32 < w_limit));
      w_cnt_wrap = (r_cnt == CNT_LAST);
      w_idx_wrap = (r_idx == IDX_LAST);
   end

   // Scan counters and slot pattern latch; they run even while disabled.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
         r_idx <= '0;
         r_pat <= 8'h00;
      end else begin
         if (r_cnt == '0) r_pat <= w_new_pat;
         if (w_cnt_wrap) begin
            r_cnt <= '0;
            r_idx <= w_idx_wrap ? '0 : r_idx + 1'b1;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   // Output registers, one cycle behind the counter state that decides them.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_seg   <= 8'h00;
         r_dig   <= '0;
         r_frame <= 1'b0;
      end else begin
         r_seg   <= w_on ? w_pat : 8'h00;
         r_dig   <= w_on ? w_onehot : '0;
         r_frame <= w_cnt_wrap && w_idx_wrap;
      end
   end

   assign segment_data = (SEG_ACT_LOW != 0) ? ~r_seg : r_seg;
   assign digit_en     = (DIG_ACT_LOW != 0) ? ~r_dig : r_dig;
   assign frame_tick   = r_frame;
endmodule

// File: tb/tb_segment_scan_driver.sv
// Directed bench for segment_scan_driver (4 digits, 32-cycle slots, 1 blank cycle).
module tb_segment_scan_driver;
   localparam int ND = 4;
   localparam int SD = 32;
   localparam int FRAME = ND * SD;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [7:0]    segment_data;
   logic [ND-1:0] digit_en;
   logic          frame_tick;
   int            cyc = 0;
   int            n_checks = 0;
   int            n_fail = 0;

   segment_scan_driver_if #(.ADDR_W(4)) bus ();

   segment_scan_driver #(
      .NUM_DIGITS(ND), .ADDR_W(4), .SCAN_DIV(SD), .BLANK_CYC(1),
      .SEG_ACT_LOW(0), .DIG_ACT_LOW(0)
   ) dut (
      .clk(clk), .reset(rst), .avs(bus),
      .segment_data(segment_data), .digit_en(digit_en), .frame_tick(frame_tick)
   );

   // clock / reset-relative time: cyc = clock edges since reset release
   always #5 clk = ~clk;
   always @(posedge clk or posedge rst) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   // ---------------- behavioural model ----------------
   typedef struct { int edge_n; int addr; logic [31:0] data; } wr_t;
   wr_t wlog[$];
   logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   // Register value as seen in counter state t (after t edges since reset).
   function automatic logic [31:0] reg_at(input int addr, input int t);
      logic [31:0] v;
      if (addr > ND) return 32'h0;
      v = (addr == ND) ? 32'h0000_0F03 : 32'h0;
      foreach (wlog[i]) begin
         if (wlog[i].edge_n <= t && wlog[i].addr == addr)
            v = (addr == ND) ? (wlog[i].data & 32'h0000_0F03) : (wlog[i].data & 32'h0000_00FF);
      end
      return v;
   endfunction

   // Expected pins when sampled in state c (outputs reflect state c-1).
   task automatic model_out(input int c, output logic [7:0] seg, output logic [ND-1:0] dig,
                            output logic ft);
      int p, cnt, idx, ss, br;
      logic [31:0] ctl_now, ctl_ss, d;
      seg = 8'h0; dig = '0;
      ft  = (c > 0) && (c % FRAME == 0);
      if (c > 0) begin
         p = c - 1; cnt = p % SD; idx = (p / SD) % ND; ss = p - cnt;
         ctl_now = reg_at(ND, p);
         br = int'(ctl_now[11:8]);
         if (ctl_now[0] && cnt >= 1 && (br == 15 || cnt < (br + 1) * (SD / 16))) begin
            ctl_ss = reg_at(ND, ss);
            d      = reg_at(idx, ss);
            seg    = ctl_ss[1] ? {d[7], glyph[d[3:0]]} : d[7:0];
            dig    = ND'(1 << idx);
         end
      end
   endtask

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cyc %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // every-cycle compare of the pins against the model
   always @(negedge clk) begin : cmp
      logic [7:0]    es;
      logic [ND-1:0] ed;
      logic          ef;
      if (rst) begin es = 8'h0; ed = '0; ef = 1'b0; end
      else model_out(cyc, es, ed, ef);
      check("seg_model", 32'(segment_data), 32'(es));
      check("dig_model", 32'(digit_en), 32'(ed));
      check("tick_model", 32'(frame_tick), 32'(ef));
   end

   // ---------------- driver tasks (called at a falling edge) ----------------
   task automatic do_write(input int addr, input logic [31:0] data);
      bus.avs_address   = 4'(addr);
      bus.avs_writedata = data;
      bus.avs_write     = 1'b1;
      wlog.push_back('{cyc + 1, addr, data});
      @(negedge clk);
      bus.avs_write = 1'b0;
   endtask

   task automatic do_read(input int addr, input logic [31:0] lit, input string name);
      logic [31:0] exp;
      bus.avs_address = 4'(addr);
      bus.avs_read    = 1'b1;
      exp = reg_at(addr, cyc);
      @(posedge clk); #1;
      bus.avs_read = 1'b0;
      check(name, bus.avs_readdata, exp);
      check({name, "_lit"}, bus.avs_readdata, lit);
      @(negedge clk);
   endtask

   task automatic do_write_read(input int addr, input logic [31:0] data, input logic [31:0] lit_old);
      logic [31:0] exp;
      bus.avs_address   = 4'(addr);
      bus.avs_writedata = data;
      bus.avs_write     = 1'b1;
      bus.avs_read      = 1'b1;
      exp = reg_at(addr, cyc);
      wlog.push_back('{cyc + 1, addr, data});
      @(posedge clk); #1;
      bus.avs_write = 1'b0;
      bus.avs_read  = 1'b0;
      check("rd_during_wr", bus.avs_readdata, exp);
      check("rd_during_wr_lit", bus.avs_readdata, lit_old);
      @(negedge clk);
   endtask

   task automatic wait_state(input int cnt, input int idx);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!((cyc % SD) == cnt && ((cyc / SD) % ND) == idx) && n < 300);
      if (n >= 300) check("wait_state_timeout", 32'(n), 32'(0));
   endtask

   task automatic count_on(input int lit, input string name);
      int on;
      on = 0;
      wait_state(0, 0);
      repeat (SD) begin
         @(negedge clk);
         if (digit_en != '0) on++;
      end
      check(name, 32'(on), 32'(lit));
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int ticks, first_tick;
      bus.avs_address = '0; bus.avs_write = 1'b0; bus.avs_writedata = '0; bus.avs_read = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // post-reset scan: hex 0 glyph on every digit, one frame tick per 128 cycles
      ticks = 0; first_tick = -1;
      for (int i = 1; i <= 260; i++) begin
         @(negedge clk);
         if (frame_tick) begin
            ticks++;
            if (first_tick < 0) first_tick = cyc;
         end
         if (i == 10) begin
            check("reset_dig0", 32'(digit_en), 32'h1);
            check("reset_seg0", 32'(segment_data), 32'h3F);
         end
         if (i == 40) check("reset_dig1", 32'(digit_en), 32'h2);
      end
      check("tick_count", 32'(ticks), 32'd2);
      check("tick_first", 32'(first_tick), 32'd128);

      // register reads and readdata hold
      do_read(9, 32'h0, "rd_addr9");
      do_read(4, 32'h0000_0F03, "rd_ctrl_reset");
      repeat (3) @(negedge clk);
      check("rd_hold", bus.avs_readdata, 32'h0000_0F03);

      // hex decode with decimal point, then raw mode
      do_write(1, 32'h0000_008A);
      wait_state(0, 2); wait_state(5, 1);
      check("hex_A_dp_seg", 32'(segment_data), 32'hF7);
      check("hex_A_dp_dig", 32'(digit_en), 32'h2);
      do_write(4, 32'h0000_0F01);
      wait_state(0, 2); wait_state(5, 1);
      check("raw_seg", 32'(segment_data), 32'h8A);

      // brightness: 0 -> 1 cycle, 7 -> 15 cycles, 15 -> 31 cycles per slot
      do_write(4, 32'h0000_0001);
      count_on(1, "bright0_on");
      do_write(4, 32'h0000_0701);
      count_on(15, "bright7_on");
      do_write(4, 32'h0000_0F01);
      count_on(31, "bright15_on");

      // mid-slot write is deferred to the next slot of that digit
      do_write(2, 32'h0000_0011);
      do_write(3, 32'h0000_005A);
      wait_state(0, 3); wait_state(9, 2);
      do_write(2, 32'h0000_0022);
      wait_state(20, 2);
      check("midslot_old", 32'(segment_data), 32'h11);
      wait_state(5, 2);
      check("midslot_new", 32'(segment_data), 32'h22);

      // simultaneous write/read returns old value; unmapped write ignored
      do_write_read(4, 32'h0000_0F03, 32'h0000_0F01);
      do_read(4, 32'h0000_0F03, "rd_ctrl_new");
      do_write(9, 32'hFFFF_FFFF);
      do_read(9, 32'h0, "rd_addr9_after_wr");

      // disable: pins go dark within 2 cycles, frame ticks keep coming
      do_write(4, 32'h0000_0F02);
      @(negedge clk);
      check("disable_dig", 32'(digit_en), 32'h0);
      ticks = 0;
      repeat (FRAME) begin
         @(negedge clk);
         if (frame_tick) ticks++;
      end
      check("disable_ticks", 32'(ticks), 32'd1);
      do_write(4, 32'h0000_0F01);

      // asynchronous reset in the middle of slot 3
      wait_state(0, 0); wait_state(10, 3);
      check("pre_reset_dig", 32'(digit_en), 32'h8);
      check("pre_reset_seg", 32'(segment_data), 32'h5A);
      @(posedge clk); #2;
      rst = 1'b1;
      wlog.delete();
      #1;
      check("async_reset_dig", 32'(digit_en), 32'h0);
      check("async_reset_seg", 32'(segment_data), 32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      check("restart_dig", 32'(digit_en), 32'h1);
      check("restart_seg", 32'(segment_data), 32'h3F);
      do_read(2, 32'h0, "rd_digit2_after_reset");
      repeat (10) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
